// File: rtl/operand2_shifter_if.sv
// Request/response bundle for the operand-2 barrel shifter.
// The master issues requests and consumes results; the slave is the shifter.
interface operand2_shifter_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] val_rm;
    logic [7:0]        val_rs;
    logic [11:0]       shift_operand;
    logic              imm;
    logic              mem_op;
    logic              carry_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] val2;
    logic              carry_out;

    modport master (
        output in_valid, val_rm, val_rs, shift_operand, imm, mem_op, carry_in, out_ready,
        input  in_ready, out_valid, val2, carry_out
    );

    modport slave (
        input  in_valid, val_rm, val_rs, shift_operand, imm, mem_op, carry_in, out_ready,
        output in_ready, out_valid, val2, carry_out
    );
endinterface

// File: rtl/operand2_shifter.sv
// Multi-cycle ARM operand-2 shifter. Trivial encodings resolve in one edge;
// real shifts retire up to STEP bits per cycle using the result register as
// the accumulator. One request in flight, valid/ready on both sides.
module operand2_shifter #(
    parameter int DATA_W = 32,
    parameter int STEP   = 1
) (
    input  logic              clk,
    input  logic              rst,
    operand2_shifter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
    typedef enum logic [1:0] {OP_LSL = 2'b00, OP_LSR = 2'b01, OP_ASR = 2'b10, OP_ROR = 2'b11} shift_op_t;

    localparam logic [31:0] W     = 32'(DATA_W);
    localparam logic [7:0]  STEP8 = 8'(STEP);

    state_t            state;
    shift_op_t         op;
    logic [7:0]        remaining;
    logic [DATA_W-1:0] val2_q;
    logic              carry_q;
    logic              out_valid_q;
    logic              in_ready_q;

    // Register-form amount decode, including the immediate #0 special encodings.
    shift_op_t reg_op;
    logic      amt_imm_zero;
    logic      is_rrx;
    logic [31:0] raw_amt;
    logic [31:0] eff_amt;
    logic [31:0] ror_amt;
    logic [4:0]  imm_rot;

    assign reg_op       = shift_op_t'(bus.shift_operand[6:5]);
    assign raw_amt      = bus.shift_operand[4] ? {24'd0, bus.val_rs} : {27'd0, bus.shift_operand[11:7]};
    assign amt_imm_zero = !bus.shift_operand[4] && (bus.shift_operand[11:7] == 5'd0);
    assign eff_amt      = (amt_imm_zero && (reg_op == OP_LSR || reg_op == OP_ASR)) ? W : raw_amt;
    assign is_rrx       = amt_imm_zero && (reg_op == OP_ROR);
    assign ror_amt      = eff_amt % W;
    assign imm_rot      = {bus.shift_operand[11:8], 1'b0};

    logic              dec_done;
    logic [DATA_W-1:0] dec_val;
    logic              dec_carry;
    shift_op_t         dec_op;
    logic [7:0]        dec_cnt;

    // Decode the incoming request into either a resolved result or a shift job.
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        dec_done  = 1'b1;
        dec_val   = bus.val_rm;
        dec_carry = bus.carry_in;
        dec_op    = reg_op;
        dec_cnt   = 8'd0;
        if (bus.mem_op) begin
            dec_val = {{(DATA_W-12){bus.shift_operand[11]}}, bus.shift_operand};
        end else if (bus.imm) begin
            dec_val = {{(DATA_W-8){1'b0}}, bus.shift_operand[7:0]};
            if (imm_rot != 5'd0) begin
                dec_done = 1'b0;
                dec_op   = OP_ROR;
                dec_cnt  = {3'd0, imm_rot};
            end
        end else if (is_rrx) begin
            dec_val   = {bus.carry_in, bus.val_rm[DATA_W-1:1]};
            dec_carry = bus.val_rm[0];
        end else if (eff_amt != 32'd0) begin
            case (reg_op)
                OP_LSL, OP_LSR: begin
                    if (eff_amt == W) begin
                        dec_val   = '0;
                        dec_carry = (reg_op == OP_LSL) ? bus.val_rm[0] : bus.val_rm[DATA_W-1];
                    end else if (eff_amt > W) begin
                        dec_val   = '0;
                        dec_carry = 1'b0;
                    end else begin
                        dec_done = 1'b0;
                        dec_cnt  = 8'(eff_amt);
                    end
                end
                OP_ASR: begin
                    if (eff_amt >= W) begin
                        dec_val   = {DATA_W{bus.val_rm[DATA_W-1]}};
                        dec_carry = bus.val_rm[DATA_W-1];
                    end else begin
                        dec_done = 1'b0;
                        dec_cnt  = 8'(eff_amt);
                    end
                end
                default: begin
                    if (ror_amt == 32'd0) begin
                        dec_carry = bus.val_rm[DATA_W-1];
                    end else begin
                        dec_done = 1'b0;
                        dec_cnt  = 8'(ror_amt);
                    end
                end
            endcase
        end
    end

    logic [7:0]        step_n;
    logic [DATA_W-1:0] step_tmp;
    logic [DATA_W-1:0] step_val;
    logic              step_carry;

    // One SHIFT cycle: move by min(STEP, remaining); carry is the last bit to leave.
    always_comb begin
        step_n     = (remaining > STEP8) ? STEP8 : remaining;
        step_tmp   = val2_q;
        step_val   = val2_q;
        step_carry = carry_q;
        case (op)
            OP_LSL: begin
                step_tmp   = val2_q << (step_n - 8'd1);
                step_carry = step_tmp[DATA_W-1];
                step_val   = step_tmp << 1;
            end
            OP_LSR: begin
                step_tmp   = val2_q >> (step_n - 8'd1);
                step_carry = step_tmp[0];
                step_val   = step_tmp >> 1;
            end
            OP_ASR: begin
                step_tmp   = $signed(val2_q) >>> (step_n - 8'd1);
                step_carry = step_tmp[0];
                step_val   = $signed(step_tmp) >>> 1;
            end
            default: begin
                step_val   = (val2_q >> step_n) | (val2_q << (W - {24'd0, step_n}));
                step_carry = step_val[DATA_W-1];
            end
        endcase
    end

    // Control FSM with registered handshake outputs; result register doubles as shift accumulator.
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            op          <= OP_LSL;
            remaining   <= 8'd0;
            val2_q      <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        op         <= dec_op;
                        remaining  <= dec_cnt;
                        val2_q     <= dec_val;
                        carry_q    <= dec_carry;
                        in_ready_q <= 1'b0;
                        if (dec_done) begin
                            state       <= S_DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state <= S_SHIFT;
                        end
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    val2_q    <= step_val;
                    carry_q   <= step_carry;
                    remaining <= remaining - step_n;
                    if (remaining == step_n) begin
                        state       <= S_DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state       <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.val2      = val2_q;
    assign bus.carry_out = carry_q;
endmodule

// File: tb/tb_operand2_shifter.sv
// Directed bench: the same request stream drives a STEP=1 and a STEP=4 shifter,
// results and latencies compared against hand-computed values.
module tb_operand2_shifter;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid      = 1'b0;
    logic        out_ready     = 1'b0;
    logic        imm           = 1'b0;
    logic        mem_op        = 1'b0;
    logic        carry_in      = 1'b0;
    logic [31:0] val_rm        = '0;
    logic [7:0]  val_rs        = '0;
    logic [11:0] shift_operand = '0;

    int n_checks = 0;
    int n_fail   = 0;

    operand2_shifter_if #(.DATA_W(DATA_W)) bus1 ();
    operand2_shifter_if #(.DATA_W(DATA_W)) bus4 ();

    assign bus1.in_valid = in_valid;       assign bus4.in_valid = in_valid;
    assign bus1.out_ready = out_ready;     assign bus4.out_ready = out_ready;
    assign bus1.imm = imm;                 assign bus4.imm = imm;
    assign bus1.mem_op = mem_op;           assign bus4.mem_op = mem_op;
    assign bus1.carry_in = carry_in;       assign bus4.carry_in = carry_in;
    assign bus1.val_rm = val_rm;           assign bus4.val_rm = val_rm;
    assign bus1.val_rs = val_rs;           assign bus4.val_rs = val_rs;
    assign bus1.shift_operand = shift_operand; assign bus4.shift_operand = shift_operand;

    operand2_shifter #(.DATA_W(DATA_W), .STEP(1)) u_step1 (.clk(clk), .rst(rst), .bus(bus1));
    operand2_shifter #(.DATA_W(DATA_W), .STEP(4)) u_step4 (.clk(clk), .rst(rst), .bus(bus4));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int cycles = 0;
        while (!(bus1.in_ready && bus4.in_ready) && cycles < 50) begin
            @(negedge clk);
            cycles++;
        end
        check({tag, "_ready_timeout"}, 32'(cycles < 50), 32'd1);
    endtask

    task automatic run_vec(input string tag, input logic [31:0] rm, input logic [7:0] rs,
                           input logic [11:0] so, input logic i, input logic m, input logic ci,
                           input logic [31:0] exp_val, input logic exp_c,
                           input int exp_lat1, input int exp_lat4, input bit hold);
        int edges = 1;
        int lat1  = 0;
        int lat4  = 0;
        wait_ready(tag);
        val_rm = rm; val_rs = rs; shift_operand = so; imm = i; mem_op = m; carry_in = ci;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (bus1.out_valid) lat1 = edges;
        if (bus4.out_valid) lat4 = edges;
        while ((lat1 == 0 || lat4 == 0) && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
            if (bus1.out_valid && lat1 == 0) lat1 = edges;
            if (bus4.out_valid && lat4 == 0) lat4 = edges;
        end
        check({tag, "_lat_s1"}, 32'(lat1), 32'(exp_lat1));
        check({tag, "_lat_s4"}, 32'(lat4), 32'(exp_lat4));
        check({tag, "_val2_s1"}, bus1.val2, exp_val);
        check({tag, "_val2_s4"}, bus4.val2, exp_val);
        check({tag, "_carry_s1"}, 32'(bus1.carry_out), 32'(exp_c));
        check({tag, "_carry_s4"}, 32'(bus4.carry_out), 32'(exp_c));
        if (hold) begin
            // Present a conflicting request while the result is parked.
            val_rm = 32'hDEAD_BEEF; val_rs = 8'd3; shift_operand = 12'h030; carry_in = ~ci;
            in_valid = 1'b1;
            for (int k = 0; k < 3; k++) begin
                @(posedge clk);
                #1;
                check({tag, "_hold_valid"}, 32'(bus1.out_valid & bus4.out_valid), 32'd1);
                check({tag, "_hold_val2"}, bus1.val2, exp_val);
                check({tag, "_hold_carry"}, 32'(bus4.carry_out), 32'(exp_c));
                check({tag, "_hold_in_ready"}, 32'(bus1.in_ready | bus4.in_ready), 32'd0);
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_drop_valid"}, 32'(bus1.out_valid | bus4.out_valid), 32'd0);
        check({tag, "_idle_val2"}, bus1.val2, exp_val);
    endtask

    initial begin
        bit saw_valid;
        #2;
        check("reset_in_ready", 32'(bus1.in_ready | bus4.in_ready), 32'd0);
        check("reset_out_valid", 32'(bus1.out_valid | bus4.out_valid), 32'd0);
        check("reset_val2", bus1.val2 | bus4.val2, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("release_in_ready_low", 32'(bus1.in_ready), 32'd0);
        @(posedge clk); #1;
        check("release_in_ready_high", 32'(bus1.in_ready & bus4.in_ready), 32'd1);

        //       tag          rm            rs      so      i     m     ci    exp_val       c     l1  l4  hold
        run_vec("imm_ror8",   32'h0,        8'd0,   12'h4FF, 1'b1, 1'b0, 1'b0, 32'hFF000000, 1'b1, 9,  3,  1'b0);
        run_vec("mem_neg",    32'h0,        8'd0,   12'hFFC, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFC, 1'b1, 1,  1,  1'b0);
        run_vec("mem_pos",    32'h0,        8'd0,   12'h7FF, 1'b0, 1'b1, 1'b0, 32'h000007FF, 1'b0, 1,  1,  1'b0);
        run_vec("imm_rot0",   32'h0,        8'd0,   12'h0AB, 1'b1, 1'b0, 1'b1, 32'h000000AB, 1'b1, 1,  1,  1'b0);
        run_vec("lsl_rs32",   32'h00000001, 8'd32,  12'h010, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1,  1,  1'b0);
        run_vec("lsl_rs33",   32'h00000001, 8'd33,  12'h010, 1'b0, 1'b0, 1'b1, 32'h0,        1'b0, 1,  1,  1'b0);
        run_vec("rrx",        32'h00000003, 8'd0,   12'h060, 1'b0, 1'b0, 1'b1, 32'h80000001, 1'b1, 1,  1,  1'b0);
        run_vec("asr4",       32'h80000010, 8'd0,   12'h240, 1'b0, 1'b0, 1'b1, 32'hF8000001, 1'b0, 5,  2,  1'b1);
        run_vec("lsr_imm0",   32'h80000000, 8'd0,   12'h020, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1,  1,  1'b0);
        run_vec("lsr_rs8",    32'h12345680, 8'd8,   12'h030, 1'b0, 1'b0, 1'b0, 32'h00123456, 1'b1, 9,  3,  1'b0);
        run_vec("ror_rs36",   32'h0000001F, 8'd36,  12'h070, 1'b0, 1'b0, 1'b0, 32'hF0000001, 1'b1, 5,  2,  1'b0);
        run_vec("ror_rs32",   32'h80000001, 8'd32,  12'h070, 1'b0, 1'b0, 1'b0, 32'h80000001, 1'b1, 1,  1,  1'b0);
        run_vec("lsr_rs0",    32'h0000ABCD, 8'd0,   12'h030, 1'b0, 1'b0, 1'b1, 32'h0000ABCD, 1'b1, 1,  1,  1'b0);
        run_vec("asr_rs40",   32'h80000000, 8'd40,  12'h050, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b1, 1,  1,  1'b0);
        run_vec("lsl_imm1",   32'h80000001, 8'd0,   12'h080, 1'b0, 1'b0, 1'b0, 32'h00000002, 1'b1, 2,  2,  1'b0);
        run_vec("lsl_rs5",    32'h08000001, 8'd5,   12'h010, 1'b0, 1'b0, 1'b0, 32'h00000020, 1'b1, 6,  3,  1'b0);

        // Reset pulsed in the middle of ROR #20.
        wait_ready("abort");
        val_rm = 32'h12345678; val_rs = 8'd0; shift_operand = 12'hA60; imm = 1'b0; mem_op = 1'b0; carry_in = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_out_valid", 32'(bus1.out_valid | bus4.out_valid), 32'd0);
        check("abort_val2", bus1.val2 | bus4.val2, 32'd0);
        check("abort_carry", 32'(bus1.carry_out | bus4.carry_out), 32'd0);
        check("abort_in_ready", 32'(bus1.in_ready | bus4.in_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort_release_in_ready", 32'(bus1.in_ready & bus4.in_ready), 32'd1);
        check("abort_release_val2", bus1.val2, 32'd0);
        saw_valid = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (bus1.out_valid || bus4.out_valid) saw_valid = 1'b1;
        end
        check("abort_no_output", 32'(saw_valid), 32'd0);
        run_vec("ror20_after", 32'h12345678, 8'd0, 12'hA60, 1'b0, 1'b0, 1'b1, 32'h45678123, 1'b0, 21, 6, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/operand2_shifter.md
OPERAND2_SHIFTER -- requirements
Module: operand2_shifter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning operand/result width; it must be even and at least 16.
REQ-002 SHALL have parameter STEP, default 1, meaning the maximum shift bits retired per cycle; it must be a power of two from 1 to 16.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, request present.
REQ-006 SHALL have port in_ready, output, 1, unit can accept a request.
REQ-007 SHALL have port val_rm, input, DATA_W, Rm operand.
REQ-008 SHALL have port val_rs, input, 8, Rs[7:0] register shift amount.
REQ-009 SHALL have port shift_operand, input, 12, instruction operand-2 field.
REQ-010 SHALL have port imm, input, 1, I bit (rotated immediate).
REQ-011 SHALL have port mem_op, input, 1, LDR/STR offset request.
REQ-012 SHALL have port carry_in, input, 1, CPSR C flag.
REQ-013 SHALL have port out_valid, output, 1, result present.
REQ-014 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-015 SHALL have port val2, output, DATA_W, shifter result.
REQ-016 SHALL have port carry_out, output, 1, shifter carry.

Function
REQ-017 SHALL implement FSM IDLE/SHIFT/DONE; in_ready=1 only in IDLE and not in reset; one request in flight.
REQ-018 SHALL accept a request on an edge with in_valid&&in_ready, capturing all operands; inputs are ignored at all other times.
REQ-019 SHALL decode with priority mem_op > imm > register form.
- mem_op: val2 = sign-extended shift_operand[11:0]; carry_out = carry_in; go to DONE.
REQ-020 SHALL, for imm, take zero-extended shift_operand[7:0] with rotate-right amount 2*shift_operand[11:8].
- Amount 0: go to DONE with carry_out = carry_in.
- Otherwise: go to SHIFT with op ROR; final carry_out = val2[DATA_W-1].
REQ-021 SHALL, for register form, take type from shift_operand[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR).
- Amount source: val_rs[7:0] when shift_operand[4]=1, else shift_operand[11:7].
REQ-022 SHALL map immediate-amount special encodings as follows:
- LSR #0 → LSR #DATA_W.
- ASR #0 → ASR #DATA_W.
- ROR #0 → RRX: val2 = {carry_in, rm[DATA_W-1:1]}, carry_out = rm[0], resolved directly to DONE.
REQ-023 SHALL resolve register-form results directly to DONE (no SHIFT cycles) in these cases:
- Amount 0: val2 = rm, carry_out = carry_in.
- LSL == DATA_W: val2 = 0, carry_out = rm[0].
- LSL > DATA_W: val2 = 0, carry_out = 0.
- LSR == DATA_W: val2 = 0, carry_out = rm[DATA_W-1].
- LSR > DATA_W: val2 = 0, carry_out = 0.
- ASR >= DATA_W: val2 = all copies of rm[DATA_W-1], carry_out = rm[DATA_W-1].
- ROR with amount mod DATA_W == 0 (and amount != 0): val2 = rm, carry_out = rm[DATA_W-1].
REQ-024 SHALL otherwise enter SHIFT with remaining count = amount (ROR uses amount mod DATA_W).
- Each SHIFT cycle shifts by n = min(STEP, remaining) and decrements remaining by n.
- carry_out = last bit shifted out.
- SHIFT → DONE when remaining reaches 0.
REQ-025 SHALL give latency: out_valid rises after acceptance edge + ceil(amount/STEP) edges; resolved cases rise after exactly 1 edge.
REQ-026 SHALL hold out_valid, val2 and carry_out stable in DONE until out_ready=1.
- DONE → IDLE on that edge; out_valid falls.
- A new request is accepted no earlier than the following edge.
REQ-027 SHALL keep val2/carry_out holding the last delivered result while in IDLE.

Reset
REQ-028 SHALL, while rst=1 (asynchronously, including mid-SHIFT or mid-DONE), force: state IDLE, out_valid=0, val2=0, carry_out=0, remaining count=0, in_ready=0.
REQ-029 SHALL drive in_ready=1 from the first clock edge after rst deasserts; an aborted request produces no output.

Verification
REQ-030 SHALL cover imm=1, shift_operand=0x4FF, STEP=1 → val2=0xFF000000, carry_out=1, out_valid after 9 edges.
REQ-031 SHALL cover mem_op=1, imm=1, shift_operand=0xFFC → val2=0xFFFFFFFC, carry_out=carry_in, out_valid after 1 edge.
REQ-032 SHALL cover register LSL with shift_operand[4]=1, rm=0x00000001:
- val_rs=32 → val2=0, carry_out=1.
- val_rs=33 → val2=0, carry_out=0.
- Both after 1 edge.
REQ-033 SHALL cover ROR #0 (RRX), rm=0x00000003, carry_in=1 → val2=0x80000001, carry_out=1.
REQ-034 SHALL cover ASR #4, rm=0x80000010, STEP=1 and STEP=4 → val2=0xF8000001, carry_out=0, out_valid after 5 and 2 edges respectively.
- Hold out_ready=0 for 3 cycles: outputs stable and in_ready=0 throughout.
REQ-035 SHALL cover rst pulsed during SHIFT of ROR #20 → out_valid=0, val2=0, in_ready=1 one edge after release; a subsequent request completes normally.
